// File: rtl/ex_divider.sv
// ex_divider: iterative restoring divider for the EX stage.
// Produces one signed/unsigned quotient or remainder per instruction,
// one quotient bit per cycle, and requests a pipeline hold while busy.
module ex_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] quo_q;     // dividend shifts out as quotient bits shift in
  logic [WIDTH-1:0] dvs_q;     // divisor magnitude
  logic [WIDTH:0]   rem_q;     // partial remainder, one guard bit for the trial
  logic [CW-1:0]    cnt_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic             is_signed;
  logic [WIDTH-1:0] src1_mag;
  logic [WIDTH-1:0] src2_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] final_d;

  // Operand magnitudes captured at start; unsigned ops pass through raw.
  always_comb begin
    is_signed = ~op[1];
    src1_mag  = (is_signed && src1[WIDTH-1]) ? -src1 : src1;
    src2_mag  = (is_signed && src2[WIDTH-1]) ? -src2 : src2;
  end

  // One restoring-division step plus sign fix-up of the would-be final result.
  always_comb begin
    // NOTE: every output of this block is assigned on all paths, so no latch is inferred.
    shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_d = trial;
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted;
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
    quo_fix = qneg_q ? -quo_d : quo_d;
    rem_fix = rneg_q ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
    final_d = op_q[0] ? rem_fix : quo_fix;
  end

  // Hold the pipeline from acceptance through the last iteration; low in DONE.
  always_comb begin
    stall = ((state_q == S_IDLE) && start && !flush) || (state_q == S_CALC);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state_q  <= S_IDLE;
      op_q     <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q   <= op;
            quo_q  <= src1_mag;
            dvs_q  <= src2_mag;
            qneg_q <= is_signed & (src1[WIDTH-1] ^ src2[WIDTH-1]);
            rneg_q <= is_signed & src1[WIDTH-1];
            rem_q  <= '0;
            cnt_q  <= '0;
            if (src2 == '0) begin
              // Divide by zero: all-ones quotient, untouched dividend as remainder.
              result_q <= op[0] ? src1 : '1;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            result_q <= final_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          // A start seen here belongs to the finishing instruction.
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_ex_divider.sv
// Self-checking bench for ex_divider: directed vectors, corner sequences
// and random operations compared against an arithmetic reference model.
module tb_ex_divider;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  ex_divider #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (start),
    .op     (op),
    .src1   (src1),
    .src2   (src2),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic, truncating division.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return o[0] ? a : 32'hFFFF_FFFF;
    if (o[1]) return o[0] ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return o[0] ? r[31:0] : q[31:0];
  endfunction

  // Issue one instruction starting at the next falling edge (cycle 0) and
  // follow it to completion, checking stall profile, latency and result.
  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int cyc;
    int bad_stall;
    bit got;
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b;
    #1 check({name, " stall_c0"}, 32'(stall), 32'd1);
    cyc = 0; bad_stall = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) got = 1'b1;
      else if (!stall) bad_stall++;
    end
    check({name, " done_seen"}, 32'(got), 32'd1);
    check({name, " latency"}, 32'(cyc), (b == 32'd0) ? 32'd1 : 32'd33);
    check({name, " stall_busy"}, 32'(bad_stall), 32'd0);
    check({name, " stall_done"}, 32'(stall), 32'd0);
    check({name, " result"}, result, exp);
  endtask

  vec_t vecs[12];
  int   done_cnt;
  logic [31:0] prior;

  initial begin
    vecs[0]  = '{"divu_100_7",   2'b10, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{"modu_100_7",   2'b11, 32'd100,        32'd7,          32'd2};
    vecs[2]  = '{"div_m7_2",     2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[3]  = '{"mod_m7_2",     2'b01, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[4]  = '{"mod_7_m2",     2'b01, 32'd7,          32'hFFFF_FFFE,  32'd1};
    vecs[5]  = '{"div_5_0",      2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[6]  = '{"modu_x_0",     2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678};
    vecs[7]  = '{"mod_m5_0",     2'b01, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
    vecs[8]  = '{"div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[9]  = '{"mod_ovf",      2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    vecs[10] = '{"divu_max_1",   2'b10, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    vecs[11] = '{"modu_1000_33", 2'b11, 32'd1000,       32'd33,         32'd10};

    rst = 1'b1; flush = 1'b0; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
    repeat (2) @(negedge clk);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table; entries 10 and 11 run back-to-back (done at 33 and 67).
    foreach (vecs[i]) do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // start during DONE is ignored: the following cycle must be plain IDLE.
    do_op("pre_ign", 2'b10, 32'd9, 32'd3, 32'd3);
    start = 1'b1; op = 2'b10; src1 = 32'd50; src2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    #1 check("done_start_ignored", 32'(stall), 32'd0);

    // flush at CALC cycle 10: back to IDLE, no done, result unchanged.
    do_op("pre_flush", 2'b10, 32'd100, 32'd7, 32'd14);
    prior = 32'd14;
    @(negedge clk);
    start = 1'b1; op = 2'b10; src1 = 32'd500; src2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush_stall", 32'(stall), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_result", result, prior);
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("flush_no_done", 32'(done_cnt), 32'd0);
    check("flush_result_hold", result, prior);

    // rst at CALC cycle 20: outputs return to reset values immediately.
    @(negedge clk);
    start = 1'b1; op = 2'b00; src1 = 32'd1234; src2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1 check("rst_mid_result", result, 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("rst_no_done", 32'(done_cnt), 32'd0);

    // flush and start together in IDLE: flush wins.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b10; src1 = 32'd77; src2 = 32'd7;
    #1 check("flush_start_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1 check("flush_start_idle", 32'(stall), 32'd0);
    check("flush_start_done", 32'(done), 32'd0);

    // Random operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int sel;
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 255));
        3:       rb = 32'hFFFF_FFFF;
        4:       rb = 32'($urandom_range(1, 255)) * 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if (sel == 5) ra = 32'h8000_0000;
      do_op($sformatf("rand%0d", k), ro, ra, rb, model(ro, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_divider.md
# ex_divider

Iterative 32-bit integer divider for the EX stage, directly downstream of the ID/EX pipeline register. It consumes the operand values (`rf_rD1_out`, `rf_rD2_out`) and the decoded divide/modulo operation latched by ID/EX. It produces one quotient or remainder per instruction using restoring division at one bit per cycle. While it works, it holds `stall` high so the hazard logic freezes PC, IF/ID and ID/EX.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is supported.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous abort; the same signal that clears ID/EX.
- `start`  in  1  an EX-stage instruction is a valid divide/modulo (`have_inst` & decoded op).
- `op`  in  2  operation: 00 div.w (signed quotient), 01 mod.w (signed remainder), 10 div.wu (unsigned quotient), 11 mod.wu (unsigned remainder).
- `src1`  in  32  dividend (ID/EX `rf_rD1_out`).
- `src2`  in  32  divisor (ID/EX `rf_rD2_out`).
- `stall`  out  1  pipeline hold request; combinational.
- `done`  out  1  `result` is valid this cycle; registered.
- `result`  out  32  quotient or remainder selected by the latched `op`; registered.

## Operation
- States:
  - IDLE: waiting for an instruction.
  - CALC: 32 iterations in progress.
  - DONE: one-cycle result presentation.
- IDLE with `start`=1 at an edge:
  - Latch `op`.
  - For signed ops, latch absolute values of the operands; for unsigned ops, latch them raw.
  - Latch the sign of the quotient (`src1[31]^src2[31]`) and the sign of the remainder (`src1[31]`); both are 0 for unsigned ops.
  - Clear the 33-bit partial remainder and the 5-bit counter, then go to CALC.
  - If `src2`==0, go straight to DONE instead.
- CALC, each cycle:
  - Shift {remainder, dividend} left by 1.
  - Trial-subtract the divisor from the remainder. If the result is non-negative, keep it and set quotient bit 1; otherwise restore and set quotient bit 0.
  - Increment the counter. After the counter=31 iteration, go to DONE.
- Entering DONE:
  - Compute `result`: the quotient (negated if the quotient sign is set) for ops 00/10, or the remainder (negated if the remainder sign is set) for ops 01/11.
  - `done`=1 for exactly the DONE cycle, then return to IDLE.
  - `start` seen in DONE is ignored; it still belongs to the finishing instruction.
- Divide by zero: quotient = 0xFFFFFFFF and remainder = `src1` unmodified, for both signed and unsigned ops.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. This falls out of the magnitude algorithm; no special case is needed.
- `stall` = (IDLE & `start` & ~`flush`) | CALC. It is low in DONE so ID/EX advances on the edge that ends DONE.
- `flush`=1 at an edge in any state: go to IDLE, `done`←0, no result produced, `result` unchanged.
- `result` holds its last value until the next completion.

## Timing
- Reset values: state IDLE, `done`=0, `result`=0, counter 0, internal registers 0. `stall` is 0 while `start`=0.
- Normal op, with `start` sampled at edge E0:
  - CALC occupies cycles 1..32.
  - DONE is cycle 33; `done`=1 and `result` is valid then.
  - Total EX occupancy is 34 cycles, with `stall` high for 33 of them (cycle 0 through cycle 32).
- Divide by zero: DONE at cycle 1. EX occupancy is 2 cycles; `stall` is high in cycle 0 only.
- `rst` mid-CALC: immediate return to IDLE with all outputs at their reset values; no partial result is ever presented.
- Simultaneous `flush` and `start` in IDLE: `flush` wins; stay in IDLE with `stall`=0.
- Back-to-back divides: the second instruction's `start` is accepted in the IDLE cycle immediately after DONE. There is no dead cycle beyond IDLE.

## Test plan
- div.wu: `src1`=100, `src2`=7 -> `done` in cycle 33, `result`=14. mod.wu on the same operands -> `result`=2. `stall` is high in cycles 0–32 and low in 33.
- Signed: div.w -7/2 -> 0xFFFFFFFD (-3); mod.w -7/2 -> 0xFFFFFFFF (-1); mod.w 7/-2 -> 1.
- Divide by zero: div.w 5/0 -> 0xFFFFFFFF at cycle 1; mod.wu 0x12345678/0 -> 0x12345678. `stall` is high only in cycle 0.
- Overflow: div.w 0x80000000/0xFFFFFFFF -> 0x80000000; mod.w on the same operands -> 0.
- Abort: `flush` pulse at cycle 10 of CALC -> IDLE next cycle, `done` never asserts, `result` keeps its prior value. An `rst` pulse at cycle 20 -> `result`=0 and `done`=0 immediately.
- Back-to-back: div.wu 0xFFFFFFFF/1 then, without gap, mod.wu 1000/33 -> results 0xFFFFFFFF at cycle 33 and 10 at cycle 67, with one IDLE cycle between the two runs.
